// File: rtl/pipe_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds the access-size encoding, FSM states and byte-enable base patterns.
package pipe_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } memsize_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Size code 2'b11 behaves as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge port shared by the stage and the memory.
// Request fields stay constant while mem_req is high; mem_ack is a one-cycle pulse.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage_load_align.sv
// Extracts the addressed byte/half/word lane from read data and extends it.
// Purely combinational, zero latency.
// No flow control; consumer samples the result when the ack arrives.
module load_align
    import pipe_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] value
);
    logic [31:0] shifted;
    logic [15:0] half;

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (size)
            SZ_BYTE: value = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: value = {{16{sign_ext & half[15]}}, half};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: passes ALU results through, performs loads/stores over req/ack.
// Latency: 1 cycle for non-memory ops, k+1 cycles for a memory op acked k cycles after issue.
// Backpressure: out_hold (registered, equals WAIT state) freezes upstream while an access is pending.
module memory_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_stall,
    input  logic [4:0]            in_regdest,
    input  logic                  in_writereg,
    input  logic [31:0]           in_wbvalue,
    input  logic [31:0]           in_storedata,
    input  logic                  in_memread,
    input  logic                  in_memwrite,
    input  logic [1:0]            in_memsize,
    input  logic                  in_memsigned,
    memory_stage_if.master        mem,
    output logic                  out_hold,
    output logic                  out_stall,
    output logic [4:0]            out_regdest,
    output logic                  out_writereg,
    output logic [31:0]           out_wbvalue,
    output logic                  out_misalign,
    output logic                  out_buserr
);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  lat_regdest_q, lat_regdest_d;
    logic        lat_writereg_q, lat_writereg_d;
    logic [1:0]  lat_size_q, lat_size_d;
    logic        lat_signed_q, lat_signed_d;
    logic [1:0]  lat_addr_q, lat_addr_d;
    logic        lat_load_q, lat_load_d;
    logic        req_d, we_d;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  be_d;
    logic        stall_d, writereg_d, misalign_d, buserr_d;
    logic [4:0]  regdest_d;
    logic [31:0] wbvalue_d, load_value;
    logic        is_mem;

    load_align u_load_align (
        .rdata    (mem.mem_rdata),
        .addr_lo  (lat_addr_q),
        .size     (lat_size_q),
        .sign_ext (lat_signed_q),
        .value    (load_value)
    );

    assign is_mem   = in_memread | in_memwrite;
    assign out_hold = (state_q == ST_WAIT);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        lat_regdest_d  = lat_regdest_q;
        lat_writereg_d = lat_writereg_q;
        lat_size_d     = lat_size_q;
        lat_signed_d   = lat_signed_q;
        lat_addr_d     = lat_addr_q;
        lat_load_d     = lat_load_q;
        req_d          = mem.mem_req;
        we_d           = mem.mem_we;
        addr_d         = mem.mem_addr;
        wdata_d        = mem.mem_wdata;
        be_d           = mem.mem_be;
        stall_d        = 1'b1;
        regdest_d      = 5'd0;
        writereg_d     = 1'b0;
        wbvalue_d      = 32'd0;
        misalign_d     = 1'b0;
        buserr_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!in_stall) begin
                    if (!is_mem) begin
                        stall_d    = 1'b0;
                        regdest_d  = in_regdest;
                        writereg_d = in_writereg;
                        wbvalue_d  = in_wbvalue;
                    end else if (is_misaligned(in_memsize, in_wbvalue[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d        = ST_WAIT;
                        cnt_d          = 32'd0;
                        lat_regdest_d  = in_regdest;
                        lat_writereg_d = in_writereg;
                        lat_size_d     = in_memsize;
                        lat_signed_d   = in_memsigned;
                        lat_addr_d     = in_wbvalue[1:0];
                        lat_load_d     = in_memread;
                        req_d          = 1'b1;
                        we_d           = ~in_memread;
                        addr_d         = {in_wbvalue[31:2], 2'b00};
                        wdata_d        = in_storedata;
                        be_d           = BE_WORD;
                        // Loads always fetch the whole word; lane select happens on return.
                        if (!in_memread) begin
                            case (in_memsize)
                                SZ_BYTE: begin
                                    wdata_d = {4{in_storedata[7:0]}};
                                    be_d    = BE_BYTE << in_wbvalue[1:0];
                                end
                                SZ_HALF: begin
                                    wdata_d = {2{in_storedata[15:0]}};
                                    be_d    = BE_HALF << {in_wbvalue[1], 1'b0};
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (mem.mem_ack) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    stall_d   = 1'b0;
                    regdest_d = lat_regdest_q;
                    if (lat_load_q) begin
                        writereg_d = lat_writereg_q;
                        wbvalue_d  = load_value;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    buserr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 32'd0;
            lat_regdest_q  <= 5'd0;
            lat_writereg_q <= 1'b0;
            lat_size_q     <= 2'b00;
            lat_signed_q   <= 1'b0;
            lat_addr_q     <= 2'b00;
            lat_load_q     <= 1'b0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= 32'd0;
            mem.mem_wdata  <= 32'd0;
            mem.mem_be     <= 4'd0;
            out_stall      <= 1'b1;
            out_regdest    <= 5'd0;
            out_writereg   <= 1'b0;
            out_wbvalue    <= 32'd0;
            out_misalign   <= 1'b0;
            out_buserr     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lat_regdest_q  <= lat_regdest_d;
            lat_writereg_q <= lat_writereg_d;
            lat_size_q     <= lat_size_d;
            lat_signed_q   <= lat_signed_d;
            lat_addr_q     <= lat_addr_d;
            lat_load_q     <= lat_load_d;
            mem.mem_req    <= req_d;
            mem.mem_we     <= we_d;
            mem.mem_addr   <= addr_d;
            mem.mem_wdata  <= wdata_d;
            mem.mem_be     <= be_d;
            out_stall      <= stall_d;
            out_regdest    <= regdest_d;
            out_writereg   <= writereg_d;
            out_wbvalue    <= wbvalue_d;
            out_misalign   <= misalign_d;
            out_buserr     <= buserr_d;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a result scoreboard; TIMEOUT set to 4.
module tb_memory_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_stall;
    logic [4:0]  in_regdest;
    logic        in_writereg;
    logic [31:0] in_wbvalue;
    logic [31:0] in_storedata;
    logic        in_memread;
    logic        in_memwrite;
    logic [1:0]  in_memsize;
    logic        in_memsigned;
    logic        out_hold, out_stall, out_writereg, out_misalign, out_buserr;
    logic [4:0]  out_regdest;
    logic [31:0] out_wbvalue;

    memory_stage_if mem ();

    memory_stage #(.TIMEOUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_stall     (in_stall),
        .in_regdest   (in_regdest),
        .in_writereg  (in_writereg),
        .in_wbvalue   (in_wbvalue),
        .in_storedata (in_storedata),
        .in_memread   (in_memread),
        .in_memwrite  (in_memwrite),
        .in_memsize   (in_memsize),
        .in_memsigned (in_memsigned),
        .mem          (mem.master),
        .out_hold     (out_hold),
        .out_stall    (out_stall),
        .out_regdest  (out_regdest),
        .out_writereg (out_writereg),
        .out_wbvalue  (out_wbvalue),
        .out_misalign (out_misalign),
        .out_buserr   (out_buserr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] wb;
        logic        mis;
        logic        berr;
        logic        full;
    } res_t;

    res_t q[$];
    int checks = 0;
    int failures = 0;
    int hold_cnt = 0;
    int req_cnt = 0;
    int berr_cnt = 0;
    int mis_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        res_t e;
        if (out_hold === 1'b1) hold_cnt++;
        if (mem.mem_req === 1'b1) req_cnt++;
        if (out_buserr === 1'b1) berr_cnt++;
        if (out_misalign === 1'b1) mis_cnt++;
        if (out_stall !== 1'b1 || out_misalign === 1'b1 || out_buserr === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_result", {31'd0, out_stall, out_wbvalue}, {32'd1, 32'd0});
            end else begin
                e = q.pop_front();
                chk("res_stall", 64'(out_stall), 64'(e.stall));
                chk("res_writereg", 64'(out_writereg), 64'(e.wr));
                chk("res_misalign", 64'(out_misalign), 64'(e.mis));
                chk("res_buserr", 64'(out_buserr), 64'(e.berr));
                if (e.full) begin
                    chk("res_regdest", 64'(out_regdest), 64'(e.rd));
                    chk("res_wbvalue", 64'(out_wbvalue), 64'(e.wb));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        monitor();
    endtask

    task automatic drive(input logic [4:0] rd, input logic wr, input logic [31:0] wb,
                         input logic [31:0] sd, input logic rdn, input logic wrn,
                         input logic [1:0] sz, input logic sg);
        in_stall     = 1'b0;
        in_regdest   = rd;
        in_writereg  = wr;
        in_wbvalue   = wb;
        in_storedata = sd;
        in_memread   = rdn;
        in_memwrite  = wrn;
        in_memsize   = sz;
        in_memsigned = sg;
    endtask

    task automatic push(input logic st, input logic [4:0] rd, input logic wr, input logic [31:0] wb,
                        input logic mis, input logic berr, input logic full);
        res_t r;
        r = '{stall: st, rd: rd, wr: wr, wb: wb, mis: mis, berr: berr, full: full};
        q.push_back(r);
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        in_stall = 1'b1;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_stall", 64'(out_stall), 64'd1);
        chk("rst_bundle", {out_regdest, out_writereg, out_wbvalue, out_misalign, out_buserr}, 64'd0);
        chk("rst_mem", {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_be}, 64'd0);
        chk("rst_hold", 64'(out_hold), 64'd0);
        reset = 1'b0;
        tick();

        // Two back-to-back ALU ops.
        hold_cnt = 0;
        drive(5'd5, 1'b1, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        push(1'b0, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        tick();
        drive(5'd6, 1'b0, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        push(1'b0, 5'd6, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1);
        tick();
        in_stall = 1'b1;
        tick();
        chk("alu_hold_cnt", 64'(hold_cnt), 64'd0);
        chk("alu_bubble", 64'(out_stall), 64'd1);

        // lb signed, ack on third cycle of WAIT.
        hold_cnt = 0;
        drive(5'd7, 1'b1, 32'h0000_0103, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1);
        push(1'b0, 5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
        tick();
        chk("lb_req", {mem.mem_req, mem.mem_we, mem.mem_be}, {58'd0, 1'b1, 1'b0, 4'b1111});
        chk("lb_addr", 64'(mem.mem_addr), 64'h100);
        chk("lb_issue_bubble", 64'(out_stall), 64'd1);
        tick();
        tick();
        mem.mem_ack = 1'b1;
        mem.mem_rdata = 32'h80FF_FF7F;
        tick();
        mem.mem_ack = 1'b0;
        in_stall = 1'b1;
        chk("lb_req_drop", 64'(mem.mem_req), 64'd0);
        chk("lb_hold_cnt", 64'(hold_cnt), 64'd3);
        tick();

        // lhu from upper half.
        drive(5'd8, 1'b1, 32'h0000_0106, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0);
        push(1'b0, 5'd8, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1);
        tick();
        mem.mem_ack = 1'b1;
        mem.mem_rdata = 32'hBEEF_1234;
        tick();
        mem.mem_ack = 1'b0;
        in_stall = 1'b1;
        tick();

        // sh to upper half.
        hold_cnt = 0;
        drive(5'd9, 1'b1, 32'h0000_0102, 32'h0000_ABCD, 1'b0, 1'b1, 2'b01, 1'b0);
        push(1'b0, 5'd9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sh_be", 64'(mem.mem_be), 64'b1100);
        chk("sh_wdata", 64'(mem.mem_wdata), 64'hABCD_ABCD);
        chk("sh_we", {mem.mem_req, mem.mem_we}, 64'b11);
        mem.mem_ack = 1'b1;
        tick();
        mem.mem_ack = 1'b0;
        in_stall = 1'b1;
        chk("sh_hold_cnt", 64'(hold_cnt), 64'd1);
        tick();

        // sb to byte 1.
        drive(5'd10, 1'b0, 32'h0000_0201, 32'h1234_5699, 1'b0, 1'b1, 2'b00, 1'b0);
        push(1'b0, 5'd10, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sb_be", 64'(mem.mem_be), 64'b0010);
        chk("sb_wdata", 64'(mem.mem_wdata), 64'h9999_9999);
        chk("sb_addr", 64'(mem.mem_addr), 64'h200);
        mem.mem_ack = 1'b1;
        tick();
        mem.mem_ack = 1'b0;
        in_stall = 1'b1;
        tick();

        // Misaligned lw: bubble with misalign pulse, no request.
        req_cnt = 0;
        mis_cnt = 0;
        drive(5'd11, 1'b1, 32'h0000_0101, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        push(1'b1, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("mis_hold", 64'(out_hold), 64'd0);
        in_stall = 1'b1;
        tick();
        tick();
        chk("mis_req_cnt", 64'(req_cnt), 64'd0);
        chk("mis_pulse_cnt", 64'(mis_cnt), 64'd1);

        // Timeout: no ack, request held 4 cycles then buserr.
        req_cnt = 0;
        berr_cnt = 0;
        drive(5'd3, 1'b1, 32'h0000_0200, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        push(1'b1, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        in_stall = 1'b1;
        chk("to_req_low", 64'(mem.mem_req), 64'd0);
        chk("to_hold_low", 64'(out_hold), 64'd0);
        tick();
        tick();
        chk("to_req_cnt", 64'(req_cnt), 64'd4);
        chk("to_berr_cnt", 64'(berr_cnt), 64'd1);

        // Ack on the 4th request cycle wins over the timeout.
        berr_cnt = 0;
        drive(5'd4, 1'b1, 32'h0000_0204, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        push(1'b0, 5'd4, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        mem.mem_ack = 1'b1;
        mem.mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem.mem_ack = 1'b0;
        in_stall = 1'b1;
        tick();
        chk("ackwin_berr_cnt", 64'(berr_cnt), 64'd0);

        // Reset mid-WAIT, late ack ignored.
        drive(5'd12, 1'b1, 32'h0000_0300, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        tick();
        chk("rw_req_before", 64'(mem.mem_req), 64'd1);
        reset = 1'b1;
        in_stall = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_req_after", 64'(mem.mem_req), 64'd0);
        chk("rw_outputs", {out_stall, out_hold, out_regdest, out_writereg, out_misalign, out_buserr}, 64'b1_0_00000_0_0_0);
        mem.mem_ack = 1'b1;
        mem.mem_rdata = 32'h5555_5555;
        tick();
        mem.mem_ack = 1'b0;
        tick();
        chk("rw_late_ack", {out_stall, out_hold, out_wbvalue}, {30'd0, 1'b1, 1'b0, 32'd0});

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
